// File: rtl/spram_req_ctrl_pkg.sv
// Shared types and defaults for the single-port RAM request controller.
package spram_req_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 128;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/spram_resp_fifo.sv
// Two-entry read-response FIFO; push and pop in the same cycle are legal even when full.
module spram_resp_fifo
   import spram_req_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = pop && (r_count != 2'd0);
   assign w_push = push && ((r_count != 2'd2) || w_pop);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is not reset; the count qualifies every entry, so stale data is never visible.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule

// File: rtl/spram_req_ctrl.sv
// Request controller in front of a latency-1 single-port RAM: zero-fill sweep, then
// credit-limited read/write issue with an in-order 2-entry response FIFO.
module spram_req_ctrl
   import spram_req_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int DEPTH         = DEF_DEPTH,
   parameter int INIT_ON_RESET = 1,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [AW-1:0]         req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  init_done,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [AW-1:0]         ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam state_t        RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        r_state;
   state_t        w_state_next;
   logic [AW-1:0] r_sweep;
   logic          r_inflight;
   logic [1:0]    w_fifo_count;
   logic          w_pop;
   logic [2:0]    w_credit;
   logic          w_fire;

   assign resp_valid = (w_fifo_count != 2'd0);
   assign w_pop      = resp_valid && resp_ready;

   // A pop this cycle frees a slot, so readiness may follow resp_ready combinationally.
   assign w_credit  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign req_ready = !rst && (r_state == ST_RUN) && (w_credit < 3'd2);
   assign w_fire    = req_valid && req_ready;
   assign init_done = !rst && (r_state == ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= RST_STATE;
         r_sweep    <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_inflight <= w_fire && !req_we;
         if (r_state == ST_INIT) r_sweep <= r_sweep + AW'(1);
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_state_next = r_state;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = req_addr;
      ram_din      = req_wdata;
      if (!rst) begin
         if (r_state == ST_INIT) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = r_sweep;
            ram_din  = '0;
            if (r_sweep == LAST_ADDR) w_state_next = ST_RUN;
         end else if (w_fire) begin
            ram_en = 1'b1;
            ram_we = req_we;
         end
      end
   end

   // RAM read data lands one cycle after the read fire, exactly when r_inflight is set.
   spram_resp_fifo #(
      .WIDTH (DATA_WIDTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_inflight),
      .din   (ram_dout),
      .pop   (w_pop),
      .dout  (resp_rdata),
      .count (w_fifo_count)
   );

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Bench for spram_req_ctrl: RAM model, scoreboard of expected read data, per-feature tasks.
module tb_spram_req_ctrl;

   localparam int DW = 32;
   localparam int DP = 128;
   localparam int AW = 7;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_rdata;
   logic          init_done;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   logic          d0_req_valid;
   logic          d0_req_ready;
   logic          d0_req_we;
   logic [AW-1:0] d0_req_addr;
   logic [DW-1:0] d0_req_wdata;
   logic          d0_resp_valid;
   logic          d0_resp_ready;
   logic [DW-1:0] d0_resp_rdata;
   logic          d0_init_done;
   logic          d0_ram_en;
   logic          d0_ram_we;
   logic [AW-1:0] d0_ram_addr;
   logic [DW-1:0] d0_ram_din;
   logic [DW-1:0] d0_ram_dout;

   logic [DW-1:0] ram_arr [DP];
   logic [DW-1:0] m_mem   [DP];
   logic [DW-1:0] exp_q   [$];
   int            n_cmp;
   int            n_err;

   spram_req_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP), .INIT_ON_RESET(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .init_done(init_done),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   spram_req_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP), .INIT_ON_RESET(0)) dut_nosweep (
      .clk(clk), .rst(rst),
      .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_we(d0_req_we),
      .req_addr(d0_req_addr), .req_wdata(d0_req_wdata),
      .resp_valid(d0_resp_valid), .resp_ready(d0_resp_ready), .resp_rdata(d0_resp_rdata),
      .init_done(d0_init_done),
      .ram_en(d0_ram_en), .ram_we(d0_ram_we), .ram_addr(d0_ram_addr),
      .ram_din(d0_ram_din), .ram_dout(d0_ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Latency-1, write-first single-port RAM.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram_arr[ram_addr] <= ram_din;
            ram_dout          <= ram_din;
         end else begin
            ram_dout <= ram_arr[ram_addr];
         end
      end
   end

   // Scoreboard: reads push expected data at fire; responses are compared at the FIFO head.
   always @(negedge clk) begin
      if (!rst) begin
         if (req_valid && req_ready) begin
            if (req_we) m_mem[req_addr] = req_wdata;
            else        exp_q.push_back(m_mem[req_addr]);
         end
         if (resp_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL resp_unexpected: got rdata=%h, required no response", resp_rdata);
            end else begin
               if (resp_rdata !== exp_q[0]) begin
                  n_err++;
                  $display("FAIL resp_data: got %h, required %h", resp_rdata, exp_q[0]);
               end
               if (resp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst        = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      exp_q.delete();
      for (int i = 0; i < DP; i++) m_mem[i] = '0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({ram_en, req_ready, init_done, resp_valid, d0_ram_en, d0_req_ready} !== 6'b0) begin
         n_err++;
         $display("FAIL in_reset: got en/rdy/done/rv/d0en/d0rdy=%b, required 000000",
                  {ram_en, req_ready, init_done, resp_valid, d0_ram_en, d0_req_ready});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Call right after reset release: 128 sweep cycles, then RUN on cycle 129.
   task automatic check_sweep(input bit chk_nosweep);
      logic [44:0] obs;
      logic [44:0] exp;
      for (int i = 0; i < DP; i++) begin
         @(negedge clk);
         obs = {ram_en, ram_we, init_done, req_ready, resp_valid, ram_addr, ram_din};
         exp = {5'b11000, 7'(i), 32'h0};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL sweep_cycle%0d: got %h, required %h", i, obs, exp);
         end
         if (chk_nosweep) begin
            n_cmp++;
            if ({d0_init_done, d0_req_ready, d0_ram_en, d0_ram_we} !== 4'b1100) begin
               n_err++;
               $display("FAIL nosweep_cycle%0d: got done/rdy/en/we=%b, required 1100", i,
                        {d0_init_done, d0_req_ready, d0_ram_en, d0_ram_we});
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({init_done, req_ready, ram_en} !== 3'b110) begin
         n_err++;
         $display("FAIL sweep_done: got done/rdy/en=%b, required 110", {init_done, req_ready, ram_en});
      end
   endtask

   task automatic drive_req(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int waited;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = data;
      waited    = 0;
      @(negedge clk);
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL req_timeout: got req_ready=0 for 50 cycles, required 1");
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_sweep(1'b0);
   endtask

   task automatic test_no_sweep();
      do_reset();
      check_sweep(1'b1);
   endtask

   task automatic test_write_read();
      drive_req(1'b1, 7'd5, 32'hDEADBEEF);
      drive_req(1'b0, 7'd5, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL raw_early: got resp_valid=%b one cycle after fire, required 0", resp_valid);
      end
      @(negedge clk);
      n_cmp++;
      if ({resp_valid, resp_rdata} !== {1'b1, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL raw_resp: got valid=%b data=%h, required 1 deadbeef", resp_valid, resp_rdata);
      end
      drive_req(1'b0, 7'd6, 32'h0);
      idle(4);
   endtask

   task automatic test_back_to_back();
      logic [19:0] hist;
      logic [19:0] exp_hist;
      for (int i = 0; i < 16; i++) drive_req(1'b1, 7'(i), 32'(i * 3));
      exp_hist = '0;
      for (int k = 2; k < 18; k++) exp_hist[k] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         req_valid = (k < 16);
         req_we    = 1'b0;
         req_addr  = 7'(k);
         @(negedge clk);
         if (k < 16) begin
            n_cmp++;
            if (req_ready !== 1'b1) begin
               n_err++;
               $display("FAIL b2b_bubble%0d: got req_ready=%b, required 1", k, req_ready);
            end
         end
         hist[k] = resp_valid;
      end
      n_cmp++;
      if (hist !== exp_hist) begin
         n_err++;
         $display("FAIL b2b_resp_train: got %b, required %b", hist, exp_hist);
      end
   endtask

   task automatic test_backpressure();
      int fires;
      fires = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         resp_ready = 1'b0;
         req_valid  = 1'b1;
         req_we     = 1'b0;
         req_addr   = 7'(7 + fires);
         @(negedge clk);
         if (req_ready) fires++;
      end
      n_cmp++;
      if (fires !== 2) begin
         n_err++;
         $display("FAIL bp_fires: got %0d, required 2", fires);
      end
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_stall: got req_ready=%b, required 0", req_ready);
      end
      @(posedge clk); #1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({resp_valid, req_ready} !== 2'b11) begin
         n_err++;
         $display("FAIL bp_release: got valid/ready=%b, required 11", {resp_valid, req_ready});
      end
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_second: got resp_valid=%b, required 1", resp_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_drained: got resp_valid=%b, required 0", resp_valid);
      end
   endtask

   task automatic test_reset_midop();
      @(posedge clk); #1;
      resp_ready = 1'b0;
      drive_req(1'b0, 7'd1, 32'h0);
      drive_req(1'b0, 7'd2, 32'h0);
      do_reset();
      check_sweep(1'b0);
      idle(4);
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      resp_ready   = 1'b1;
      d0_req_valid = 1'b0;
      d0_req_we    = 1'b0;
      d0_req_addr  = '0;
      d0_req_wdata = '0;
      d0_resp_ready = 1'b1;
      d0_ram_dout  = '0;

      test_reset();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_reset_midop();
      test_no_sweep();
      idle(3);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL resp_outstanding: got %0d pending, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
